// File: rtl/xs3_pkg.sv
// Shared constants, state encoding and code-validity helper for the
// excess-3 to BCD receive path.
package xs3_pkg;

  localparam logic [3:0] XS3_OFFSET = 4'd3;
  localparam logic [3:0] XS3_MIN    = 4'h3;
  localparam logic [3:0] XS3_MAX    = 4'hC;

  typedef enum logic {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } xs3_state_e;

  // Excess-3 only uses codes 3..C; everything outside that window is
  // a corrupted digit.
  function automatic logic xs3_valid(input logic [3:0] code);
    return (code >= XS3_MIN) && (code <= XS3_MAX);
  endfunction

endpackage

// File: rtl/xs3_digit_dec.sv
// Single-nibble excess-3 to BCD converter. Invalid codes decode to zero
// and raise err_o so the word can still be delivered with a mask.
module xs3_digit_dec
  import xs3_pkg::*;
(
  input  logic [3:0] code_i,
  output logic [3:0] bcd_o,
  output logic       err_o
);

  // Subtract the excess-3 bias, forcing zero for codes outside 3..C.
  always_comb begin
    err_o = !xs3_valid(code_i);
    bcd_o = err_o ? 4'h0 : (code_i - XS3_OFFSET);
  end

endmodule

// File: rtl/xs3_bcd_decoder.sv
// Sequential excess-3 to BCD decoder. Digits arrive MSD first over a
// valid/ready handshake, are packed DIGITS at a time and delivered with a
// per-digit invalid-code mask on a second valid/ready interface.
// Optional feature: define XS3_ERR_CNT_EN to add err_count, a saturating
// count of invalid digits accepted since reset.
module xs3_bcd_decoder
  import xs3_pkg::*;
#(
  parameter int unsigned DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [3:0]            in_digit,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   out_bcd,
  output logic                  out_err,
  output logic [DIGITS-1:0]     out_err_mask
`ifdef XS3_ERR_CNT_EN
  ,
  output logic [7:0]            err_count
`endif
);

  localparam logic [3:0] LAST_IDX = 4'(DIGITS - 1);

  xs3_state_e          state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [4*DIGITS-1:0] work_bcd_q, work_bcd_d;
  logic [DIGITS-1:0]   work_mask_q, work_mask_d;
  logic [4*DIGITS-1:0] out_bcd_q, out_bcd_d;
  logic [DIGITS-1:0]   out_mask_q, out_mask_d;
  logic                out_valid_q, out_valid_d;

  logic [3:0]          dec_bcd;
  logic                dec_err;
  logic                accept;
  logic [4*DIGITS-1:0] shift_bcd;
  logic [DIGITS-1:0]   shift_mask;

  xs3_digit_dec u_dec (
    .code_i (in_digit),
    .bcd_o  (dec_bcd),
    .err_o  (dec_err)
  );

  assign in_ready     = (state_q == COLLECT);
  assign accept       = in_valid && in_ready;
  assign out_valid    = out_valid_q;
  assign out_bcd      = out_bcd_q;
  assign out_err_mask = out_mask_q;
  assign out_err      = |out_mask_q;

  // Working register with the incoming digit shifted in at the LSB end,
  // so the first digit of a word ends up in the top nibble.
  always_comb begin
    shift_bcd        = work_bcd_q << 4;
    shift_bcd[3:0]   = dec_bcd;
    shift_mask       = work_mask_q << 1;
    shift_mask[0]    = dec_err;
  end

  // Next-state logic: collect DIGITS nibbles, then hold the word until taken.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    work_bcd_d  = work_bcd_q;
    work_mask_d = work_mask_q;
    out_bcd_d   = out_bcd_q;
    out_mask_d  = out_mask_q;
    out_valid_d = out_valid_q;
    case (state_q)
      COLLECT: begin
        if (accept) begin
          if (cnt_q == LAST_IDX) begin
            cnt_d       = 4'd0;
            out_bcd_d   = shift_bcd;
            out_mask_d  = shift_mask;
            out_valid_d = 1'b1;
            work_bcd_d  = '0;
            work_mask_d = '0;
            state_d     = HOLD;
          end else begin
            cnt_d       = cnt_q + 4'd1;
            work_bcd_d  = shift_bcd;
            work_mask_d = shift_mask;
          end
        end
      end
      HOLD: begin
        if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
          state_d     = COLLECT;
        end
      end
      default: begin
        state_d = COLLECT;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= COLLECT;
      cnt_q       <= 4'd0;
      work_bcd_q  <= '0;
      work_mask_q <= '0;
      out_bcd_q   <= '0;
      out_mask_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      work_bcd_q  <= work_bcd_d;
      work_mask_q <= work_mask_d;
      out_bcd_q   <= out_bcd_d;
      out_mask_q  <= out_mask_d;
      out_valid_q <= out_valid_d;
    end
  end

`ifdef XS3_ERR_CNT_EN
  logic [7:0] err_cnt_q, err_cnt_d;

  // Saturating tally of invalid digits actually accepted.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (accept && dec_err && (err_cnt_q != 8'hFF)) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  // Error counter register, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt_q <= 8'd0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign err_count = err_cnt_q;
`endif

endmodule
